serial_bus_arbiter: RTL and testbench

SERIAL_BUS_ARBITER -- requirements
Module: serial_bus_arbiter

---
 rtl/serial_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_serial_bus_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter: two-requester arbiter in front of an 8-bit serial bus.
// A transaction is ADDR (4 bytes, LSB first), CMD (1 byte, bit0 = write),
// DATA (4 bytes, driven for writes, sampled from bus_in for reads), DONE.
// Build option: define SERIAL_BUS_FIXED_PRIO_EN for fixed priority
// (requester 0 wins). Left undefined, contention is resolved round-robin.
// Handshake: a requester holds req until it sees gnt; from the first ADDR
// cycle the request is latched, later req/addr/we/wdata changes are ignored,
// and done pulses for one cycle (with gnt still high) when the owner is finished.
module serial_bus_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [31:0] rdata,
    output logic [7:0]  bus_out,
    output logic        bus_oe,
    input  logic [7:0]  bus_in,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_CMD  = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt;
    logic        owner;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        sel_owner;
    logic [31:0] addr_sh;
    logic [31:0] wdata_sh;

`ifdef SERIAL_BUS_FIXED_PRIO_EN
    // Fixed priority: requester 1 only wins when requester 0 is idle.
    assign sel_owner = ~req[0];
`else
    logic last_owner;

    // Round-robin: on contention pick the requester not served last.
    assign sel_owner = (req == 2'b11) ? ~last_owner : req[1];

    // Remember who was granted; reset value makes requester 0 win first.
    always_ff @(posedge clk) begin
        if (rst)
            last_owner <= 1'b1;
        else if (state == S_IDLE && req != 2'b00)
            last_owner <= sel_owner;
    end
`endif

    // State register, in-state byte counter, request latch and read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 2'd0;
            owner   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata   <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt <= 2'd0;
            else
                cnt <= cnt + 2'd1;
            if (state == S_IDLE && req != 2'b00) begin
                owner   <= sel_owner;
                we_q    <= sel_owner ? we[1] : we[0];
                addr_q  <= sel_owner ? addr1 : addr0;
                wdata_q <= sel_owner ? wdata1 : wdata0;
            end
            if (state == S_DATA && !we_q)
                rdata[{cnt, 3'b000} +: 8] <= bus_in;
        end
    end

    // Next-state sequencing: ADDR and DATA each last four cycles.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req != 2'b00) state_nxt = S_ADDR;
            S_ADDR: if (cnt == 2'd3)  state_nxt = S_CMD;
            S_CMD:                    state_nxt = S_DATA;
            S_DATA: if (cnt == 2'd3)  state_nxt = S_DONE;
            S_DONE:                   state_nxt = S_IDLE;
            default:                  state_nxt = S_IDLE;
        endcase
    end

    // Bus and grant outputs decoded from state and the latched request.
    always_comb begin
        gnt      = 2'b00;
        done     = 2'b00;
        bus_out  = 8'd0;
        bus_oe   = 1'b0;
        busy     = (state != S_IDLE);
        addr_sh  = addr_q >> {cnt, 3'b000};
        wdata_sh = wdata_q >> {cnt, 3'b000};
        case (state)
            S_ADDR: begin
                gnt     = owner ? 2'b10 : 2'b01;
                bus_oe  = 1'b1;
                bus_out = addr_sh[7:0];
            end
            S_CMD: begin
                gnt     = owner ? 2'b10 : 2'b01;
                bus_oe  = 1'b1;
                bus_out = {7'b0, we_q};
            end
            S_DATA: begin
                gnt = owner ? 2'b10 : 2'b01;
                if (we_q) begin
                    bus_oe  = 1'b1;
                    bus_out = wdata_sh[7:0];
                end
            end
            S_DONE: begin
                gnt  = owner ? 2'b10 : 2'b01;
                done = owner ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter: single write, single read, dropped
// request, reset mid-read and back-to-back contention.
module tb_serial_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  gnt, done;
    logic [31:0] rdata;
    logic [7:0]  bus_out;
    logic        bus_oe;
    logic [7:0]  bus_in;
    logic        busy;
    logic [2:0]  state_dbg;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_q[$];

    serial_bus_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .done(done), .rdata(rdata), .bus_out(bus_out),
        .bus_oe(bus_oe), .bus_in(bus_in), .busy(busy), .state_dbg(state_dbg)
    );

    // Clock and cycle stepping: inputs change and outputs are sampled 1ns after the edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"},   32'(gnt),     32'd0);
        chk({tag, "_done"},  32'(done),    32'd0);
        chk({tag, "_busy"},  32'(busy),    32'd0);
        chk({tag, "_oe"},    32'(bus_oe),  32'd0);
        chk({tag, "_out"},   32'(bus_out), 32'd0);
        chk({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = 2'b00;
        bus_in = 8'd0;
        tick;
        tick;
        exp_rdata = 32'd0;
        chk_idle("rst");
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
    endtask

    // One complete transaction from a single requester, checking every cycle.
    task automatic run_txn(input int who, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] rd_in, input int drop_at);
        logic [1:0] oh;
        logic [7:0] b;
        oh = (who == 1) ? 2'b10 : 2'b01;
        req = oh;
        we  = w ? oh : 2'b00;
        if (who == 1) begin addr1 = a; wdata1 = d; end
        else          begin addr0 = a; wdata0 = d; end
        for (int k = 0; k < 4; k++) exp_q.push_back(a[8*k +: 8]);
        exp_q.push_back({7'b0, w});
        if (w) for (int k = 0; k < 4; k++) exp_q.push_back(d[8*k +: 8]);
        tick;
        for (int k = 0; k < 4; k++) begin
            chk("addr_gnt",  32'(gnt),    32'(oh));
            chk("addr_busy", 32'(busy),   32'd1);
            chk("addr_oe",   32'(bus_oe), 32'd1);
            b = exp_q.pop_front();
            chk("addr_byte", 32'(bus_out), 32'(b));
            if (k == 0) begin
                addr0 = ~a; addr1 = ~a; wdata0 = ~d; wdata1 = ~d; we = ~we;
            end
            if (k == drop_at) req = 2'b00;
            tick;
        end
        chk("cmd_gnt", 32'(gnt),    32'(oh));
        chk("cmd_oe",  32'(bus_oe), 32'd1);
        b = exp_q.pop_front();
        chk("cmd_byte", 32'(bus_out), 32'(b));
        tick;
        for (int k = 0; k < 4; k++) begin
            chk("data_gnt",  32'(gnt),  32'(oh));
            chk("data_done", 32'(done), 32'd0);
            if (w) begin
                chk("wdata_oe", 32'(bus_oe), 32'd1);
                b = exp_q.pop_front();
                chk("wdata_byte", 32'(bus_out), 32'(b));
            end else begin
                chk("rdata_oe", 32'(bus_oe), 32'd0);
            end
            bus_in = rd_in[8*k +: 8];
            tick;
        end
        if (!w) exp_rdata = rd_in;
        chk("done_pulse", 32'(done),    32'(oh));
        chk("done_gnt",   32'(gnt),     32'(oh));
        chk("done_oe",    32'(bus_oe),  32'd0);
        chk("done_out",   32'(bus_out), 32'd0);
        chk("done_rdata", rdata,        exp_rdata);
        chk("done_state", 32'(state_dbg), 32'd4);
        req = 2'b00;
        bus_in = 8'd0;
        tick;
        chk_idle("post");
        chk("post_rdata", rdata, exp_rdata);
    endtask

    // Directed sequence.
    initial begin
        logic [1:0]  e;
        logic [31:0] rnd;
        n_checks = 0;
        n_fail   = 0;
        req = 2'b00; we = 2'b00; addr0 = 32'd0; addr1 = 32'd0;
        wdata0 = 32'd0; wdata1 = 32'd0; bus_in = 8'd0; rst = 1'b1;
        exp_rdata = 32'd0;
        do_reset;

        // Single write from requester 0.
        run_txn(0, 1'b1, 32'h1234_5678, 32'hA1B2_C3D4, 32'd0, -1);
        // Single read from requester 1.
        run_txn(1, 1'b0, 32'hCAFE_0010, 32'd0, 32'h4433_2211, -1);
        // Write whose req drops during ADDR; rdata must survive it.
        rnd = $urandom_range(32'hFFFF_FFFF, 0);
        run_txn(0, 1'b1, 32'h0000_00F0, rnd, 32'd0, 2);

        // Reset during DATA cycle 1 of a read.
        req = 2'b10; we = 2'b00; addr1 = 32'h0BAD_F00D;
        tick;
        req = 2'b00;
        repeat (5) tick;
        chk("mid_state_data", 32'(state_dbg), 32'd3);
        bus_in = 8'h55;
        tick;
        rst = 1'b1;
        tick;
        chk_idle("mid_rst");
        chk("mid_rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        tick;
        chk_idle("mid_after");

        // Contention with both requests held.
        do_reset;
        req = 2'b11; we = 2'b00; bus_in = 8'd0;
        for (int n = 0; n < 4; n++) begin
`ifdef SERIAL_BUS_FIXED_PRIO_EN
            e = 2'b01;
`else
            e = (n % 2 == 0) ? 2'b01 : 2'b10;
`endif
            tick;
            chk("cont_gnt", 32'(gnt), 32'(e));
            repeat (9) tick;
            chk("cont_done", 32'(done), 32'(e));
            tick;
            chk("cont_idle_busy", 32'(busy), 32'd0);
        end
        req = 2'b00;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
